// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W          = 16;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  function automatic logic is_rx_state(input state_e s);
    return (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian bytes into 32-bit words; emits a one-cycle word_vld after the 4th byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              last_byte,
  output logic              word_vld,
  output logic [WORD_W-1:0] word
);

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_vld_q, word_vld_d;

  assign last_byte = (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  assign word_vld  = word_vld_q;
  assign word      = word_q;

  always_comb begin
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    if (clr) begin
      bcnt_d  = '0;
      shift_d = '0;
    end else if (byte_vld) begin
      // First byte of a word ends up in [31:24] after four shifts.
      shift_d = {shift_q[WORD_W-BYTE_W-1:0], byte_in};
      bcnt_d  = bcnt_q + BCNT_W'(1);
      if (last_byte) begin
        word_vld_d = 1'b1;
        word_d     = shift_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q     <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image, writes it into instruction memory and releases
// the processor from start-up only when the image checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              start_up,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_start_up,
  output logic              done,
  output logic              error
);

  localparam logic [CNT_W:0] MAX_WORDS = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              cpu_q, cpu_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              reload_go;
  logic              pk_vld;
  logic              pk_last;
  logic [CNT_W-1:0]  n_rx;

  assign in_ready     = !start_up && is_rx_state(state_q);
  assign accept       = in_valid && in_ready;
  assign reload_go    = reload && (state_q == ST_DONE || state_q == ST_ERROR);
  assign pk_vld       = accept && (state_q == ST_DATA);
  assign n_rx         = {hi_q, in_data};
  assign imem_addr    = addr_q;
  assign cpu_start_up = cpu_q;
  assign done         = done_q;
  assign error        = err_q;

  imem_loader_byte_packer u_byte_packer (
    .clk       (clk),
    .rst       (start_up),
    .clr       (reload_go),
    .byte_vld  (pk_vld),
    .byte_in   (in_data),
    .last_byte (pk_last),
    .word_vld  (imem_we),
    .word      (imem_wdata)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    cpu_d   = cpu_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_CNT_HI: if (accept) begin
        hi_d    = in_data;
        csum_d  = csum_q ^ in_data;
        state_d = ST_CNT_LO;
      end
      ST_CNT_LO: if (accept) begin
        csum_d = csum_q ^ in_data;
        n_d    = n_rx[ADDR_W:0];
        if ({1'b0, n_rx} > MAX_WORDS) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else if (n_rx == '0) begin
          state_d = ST_CSUM;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: if (accept) begin
        csum_d = csum_q ^ in_data;
        // Address is latched with the completing byte so it lines up with imem_we.
        if (pk_last) begin
          addr_d = wcnt_q[ADDR_W-1:0];
          wcnt_d = wcnt_q + (ADDR_W+1)'(1);
          if (wcnt_d == n_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: if (accept) begin
        if (in_data == csum_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          cpu_d   = 1'b0;
        end else begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end
      end
      ST_DONE, ST_ERROR: if (reload) begin
        state_d = ST_CNT_HI;
        hi_d    = '0;
        n_d     = '0;
        wcnt_d  = '0;
        addr_d  = '0;
        csum_d  = '0;
        cpu_d   = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = ST_CNT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start_up) begin
      state_q <= ST_CNT_HI;
      hi_q    <= '0;
      n_q     <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      cpu_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      cpu_q   <= cpu_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole frames plus hand-written corner sequences.
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int MAXW   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              start_up;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_start_up;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .start_up     (start_up),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_start_up (cpu_start_up),
    .done         (done),
    .error        (error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  // Every cycle with imem_we high is one write; a stretched strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  typedef struct {
    int n;
    bit flip;
    bit gaps;
    bit exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int v, input int i);
    if (v == 0) return (i == 0) ? 32'h2008_0005 : 32'h0109_5020;
    return {8'(v), 8'(i), 8'(~i), 8'(v * 17 + i)};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int v, input int n, input bit flip, input bit gaps);
    logic [7:0]  fb[$];
    logic [7:0]  cs;
    logic [15:0] nn;
    logic [31:0] w;
    nn = 16'(n);
    fb.push_back(nn[15:8]);
    fb.push_back(nn[7:0]);
    if (n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        w = word_of(v, i);
        fb.push_back(w[31:24]);
        fb.push_back(w[23:16]);
        fb.push_back(w[15:8]);
        fb.push_back(w[7:0]);
      end
      cs = 8'h00;
      foreach (fb[k]) cs = cs ^ fb[k];
      fb.push_back(flip ? ~cs : cs);
    end
    foreach (fb[k]) send_byte(fb[k], (gaps && k < 6) ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_cpu_start_up", 32'(cpu_start_up), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    check("reload_error", 32'(error), 32'd0);
    check("reload_in_ready", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[6];
  int   exp_wr;

  initial begin
    start_up = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_start_up", 32'(cpu_start_up), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    start_up = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    vecs[0] = '{n: 2,  flip: 1'b0, gaps: 1'b0, exp_err: 1'b0};
    vecs[1] = '{n: 2,  flip: 1'b1, gaps: 1'b0, exp_err: 1'b1};
    vecs[2] = '{n: 0,  flip: 1'b0, gaps: 1'b0, exp_err: 1'b0};
    vecs[3] = '{n: 3,  flip: 1'b0, gaps: 1'b1, exp_err: 1'b0};
    vecs[4] = '{n: 16, flip: 1'b0, gaps: 1'b0, exp_err: 1'b0};
    vecs[5] = '{n: 17, flip: 1'b0, gaps: 1'b0, exp_err: 1'b1};

    for (int v = 0; v < 6; v++) begin
      wr_addr.delete();
      wr_data.delete();
      check($sformatf("v%0d_cpu_held_before", v), 32'(cpu_start_up), 32'd1);
      send_frame(v, vecs[v].n, vecs[v].flip, vecs[v].gaps);
      check($sformatf("v%0d_done", v), 32'(done), 32'(!vecs[v].exp_err));
      check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_cpu_start_up", v), 32'(cpu_start_up), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_in_ready_idle", v), 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      exp_wr = (vecs[v].n > MAXW) ? 0 : vecs[v].n;
      check($sformatf("v%0d_write_count", v), 32'(wr_addr.size()), 32'(exp_wr));
      for (int i = 0; i < exp_wr && i < wr_addr.size(); i++) begin
        check($sformatf("v%0d_addr%0d", v, i), 32'(wr_addr[i]), 32'(i));
        check($sformatf("v%0d_data%0d", v, i), wr_data[i], word_of(v, i));
      end
      check($sformatf("v%0d_done_held", v), 32'(done), 32'(!vecs[v].exp_err));
      do_reload();
    end

    // Write strobe timing, and reload ignored mid-frame.
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    reload = 1'b1;
    send_byte(8'hAD, 0);
    reload = 1'b0;
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    check("lat_imem_we", 32'(imem_we), 32'd1);
    check("lat_imem_addr", 32'(imem_addr), 32'd0);
    check("lat_imem_wdata", imem_wdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check("lat_imem_we_single", 32'(imem_we), 32'd0);
    check("lat_cpu_still_held", 32'(cpu_start_up), 32'd1);
    send_byte(8'h23, 0);
    check("lat_done", 32'(done), 32'd1);
    check("lat_cpu_released", 32'(cpu_start_up), 32'd0);
    check("lat_write_count", 32'(wr_addr.size()), 32'd1);
    do_reload();

    // Reset after 6 of 8 data bytes: only the completed first word is written.
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 1);
    start_up = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    start_up = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_write_count", 32'(wr_addr.size()), 32'd1);
    if (wr_data.size() > 0) check("midrst_word0", wr_data[0], 32'h1122_3344);
    check("midrst_imem_addr", 32'(imem_addr), 32'd0);
    check("midrst_cpu_start_up", 32'(cpu_start_up), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    wr_addr.delete();
    wr_data.delete();
    send_frame(9, 2, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reframe_done", 32'(done), 32'd1);
    check("reframe_write_count", 32'(wr_addr.size()), 32'd2);
    for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
      check($sformatf("reframe_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("reframe_data%0d", i), wr_data[i], word_of(9, i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
